seg_scan_capture: RTL
=====================

# seg_scan_capture

Receive side of the four-digit multiplexed seven-segment display interface. The block samples active-low anode drives and active-low a-to-g segment lines, the same signals the display multiplexer sends off-chip. It decodes each lit digit back to its 4-bit hex value and holds all four values in registers. It is used as an on-chip scan monitor for self-checking display paths and for loopback tests of the board display.

## Interface

Parameters:
- SETTLE, default 4: consecutive cycles an anode pattern must stay stable before its segments are sampled (1 to 255).
- SYNC_STAGES, default 2: synchronizer depth on all inputs (2 or 3).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high.
- anodeDrives, input, 4: active-low, one-hot when a digit is lit; bit 3 selects digit A (leftmost), bit 0 selects digit D.
- sevenSegmentsa2g, input, [0:6]: active-low segments; index 0 is segment a, index 6 is segment g.
- A, B, C, D, output, 4 each: captured hex value per digit.
- digitValid, output, 4: bit 3 is A, bit 0 is D; set when the digit holds a decoded value, cleared when the digit is blank.
- frameDone, output, 1: one-cycle pulse once all four digits have been captured since the previous pulse or reset.
- segError, output, 1: one-cycle pulse when an undecodable, non-blank pattern is sampled.
- errDigit, output, 2: index of the last errored digit (3 is A, 0 is D); holds its value between errors.

## Operation

- All inputs pass through SYNC_STAGES flops. All logic below operates on the synchronized copies.
- The state machine has four states:
  - IDLE: the anode pattern is not one-hot-low (all high, or more than one low). The stable counter is held at 0.
  - SETTLE: the anode pattern is one-hot. The counter increments every cycle the anode and segment patterns are unchanged, and resets to 0 on any change, returning to SETTLE from the same or a new pattern. When the count reaches SETTLE-1, the machine moves to CAPTURE.
  - CAPTURE: a single cycle. The decoded value is written to the selected digit register, or a blank or error is recorded instead. The machine then moves to HOLD.
  - HOLD: no re-capture while the anode pattern is unchanged. On an anode change the machine goes to SETTLE if the new pattern is one-hot, otherwise to IDLE. A segment-only change also returns the machine to SETTLE, so a refresh of the same digit is re-captured.
- Decode uses the 16 standard hex glyphs (0-9, A, b, C, d, E, F), matching the display encoder's table.
  - Blank (all segments high): clear digitValid for the selected digit; the value register is held unchanged.
  - Unknown pattern: pulse segError, update errDigit, leave the value and digitValid unchanged.
- frameDone tracking uses an internal 4-bit seen mask. Each CAPTURE sets the bit for its digit, including blank captures but not errors. When the mask reaches 1111, pulse frameDone and clear the mask in the same cycle.
- Simultaneous events: if a CAPTURE completes the mask and is also an error, segError pulses and frameDone does not.

## Timing

- Reset values:
  - A, B, C, D = 0.
  - digitValid = 0000.
  - frameDone = 0, segError = 0.
  - errDigit = 00.
  - State = IDLE, seen mask = 0000, synchronizer flops = 1 (the inactive level).
- Latency from an input change at a pin to an updated digit output is SYNC_STAGES + SETTLE + 1 clocks. With the defaults this is 7.
- frameDone and segError assert in the cycle after CAPTURE, aligned with the register update.
- Asserting reset mid-capture returns everything to the reset values immediately. After deassertion, capture restarts from IDLE with the seen mask empty.
- A digit lit for fewer than SETTLE synchronized cycles is never captured; this filters ghosting during digit transitions.

## Configuration

- SEGCAP_RAW_EN defined: adds an output rawSegs [27:0] holding the last sampled 7-bit active-low pattern per digit. A occupies [27:21] and D occupies [6:0]. The raw pattern is updated on every CAPTURE, including blanks and errors. Its reset value is all ones.
- SEGCAP_RAW_EN not defined: the port and its storage are absent; all other behaviour is identical.

## Structure

- A shared package or include file holds:
  - the state encoding constants: IDLE, SETTLE, CAPTURE, HOLD;
  - the 16 active-low glyph constants;
  - the BLANK constant, 7'b1111111.
- One combinational sub-module, seg7_decode: takes a 7-bit pattern and outputs a 4-bit hex value plus isValid and isBlank flags.

## Test plan

- Static "1234", each digit lit 8 cycles in A→D rotation → A=1, B=2, C=3, D=4, digitValid=1111, frameDone pulses once per rotation.
- Digit B anode low for 3 cycles only (SETTLE=4) → B unchanged, no capture for B, no frameDone that rotation.
- Segment pattern 0110110 on digit C → segError pulses once, errDigit=01, C and its digitValid bit unchanged.
- All segments high on digit D → digitValid[0]=0, D holds its previous value, frameDone still fires when the other three digits are captured.
- Two anodes low at once (1001) → remains in IDLE, no captures, no pulses.
- Reset asserted during SETTLE of digit A → all outputs 0 the next cycle; after release, the first frameDone requires all four digits to be captured again.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block:
// FSM state codes, active-low hex glyph table and anode helpers.
package seg_scan_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    // Active-low glyphs, bit 6 is segment a, bit 0 is segment g
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    localparam logic [6:0] BLANK = 7'b1111111;

    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    function automatic logic is_onehot_low(input logic [3:0] an);
        return an inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    endfunction

    function automatic logic [1:0] digit_index(input logic [3:0] an);
        case (an)
            4'b0111: return 2'd3;
            4'b1011: return 2'd2;
            4'b1101: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_decode.sv
// Combinational seven-segment decoder: active-low pattern to hex
// value, with flags for a recognised glyph and for an all-dark digit.
module seg7_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       isValid,
    output logic       isBlank
);

    always_comb begin
        value   = 4'h0;
        isValid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                value   = 4'(i);
                isValid = 1'b1;
            end
        end
    end

    assign isBlank = (pattern == BLANK);

endmodule

// File: rtl/seg_scan_capture.sv
// Scan monitor that recovers four hex digits from multiplexed display
// drives. Define SEGCAP_RAW_EN to add the rawSegs per-digit pattern port.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] anodeDrives,
    input  logic [0:6] sevenSegmentsa2g,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic [3:0] digitValid,
    output logic       frameDone,
    output logic       segError,
    output logic [1:0] errDigit
`ifdef SEGCAP_RAW_EN
    ,
    output logic [27:0] rawSegs
`endif
);

    localparam logic [7:0] LAST = 8'(SETTLE - 1);
    localparam state_t ENTRY =
        (SETTLE == 1) ? ST_CAPTURE : ST_SETTLE;

    logic [10:0] sync_q [SYNC_STAGES];
    logic [10:0] cur;
    logic [10:0] pat;
    logic [7:0]  cnt;
    logic [3:0]  seen;
    logic [3:0]  val [4];
    state_t      state;

    logic [1:0] idx;
    logic [3:0] bit_sel;
    logic [3:0] seen_next;
    logic [3:0] dec_value;
    logic       dec_valid;
    logic       dec_blank;
    logic       hot;
    logic       changed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {anodeDrives, sevenSegmentsa2g};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign cur       = sync_q[SYNC_STAGES-1];
    assign hot       = is_onehot_low(cur[10:7]);
    assign changed   = (cur != pat);
    assign idx       = digit_index(pat[10:7]);
    assign bit_sel   = 4'b0001 << idx;
    assign seen_next = seen | bit_sel;

    seg7_decode u_decode (
        .pattern (pat[6:0]),
        .value   (dec_value),
        .isValid (dec_valid),
        .isBlank (dec_blank)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pat        <= '1;
            cnt        <= '0;
            seen       <= '0;
            digitValid <= '0;
            frameDone  <= 1'b0;
            segError   <= 1'b0;
            errDigit   <= '0;
            for (int i = 0; i < 4; i++)
                val[i] <= '0;
        end else begin
            frameDone <= 1'b0;
            segError  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (hot) begin
                        pat   <= cur;
                        state <= ENTRY;
                    end
                end
                ST_SETTLE: begin
                    if (!hot) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (changed) begin
                        pat   <= cur;
                        cnt   <= '0;
                        state <= ENTRY;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == LAST)
                            state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cnt   <= '0;
                    state <= ST_HOLD;
                    if (dec_valid) begin
                        val[idx]        <= dec_value;
                        digitValid[idx] <= 1'b1;
                    end else if (dec_blank) begin
                        digitValid[idx] <= 1'b0;
                    end else begin
                        segError <= 1'b1;
                        errDigit <= idx;
                    end
                    // errors never count towards a complete frame
                    if (dec_valid || dec_blank) begin
                        if (seen_next == 4'hF) begin
                            frameDone <= 1'b1;
                            seen      <= '0;
                        end else begin
                            seen <= seen_next;
                        end
                    end
                end
                ST_HOLD: begin
                    if (changed) begin
                        cnt <= '0;
                        if (hot) begin
                            pat   <= cur;
                            state <= ENTRY;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign A = val[3];
    assign B = val[2];
    assign C = val[1];
    assign D = val[0];

`ifdef SEGCAP_RAW_EN
    logic [3:0][6:0] raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            raw <= '1;
        else if (state == ST_CAPTURE)
            raw[idx] <= pat[6:0];
    end

    assign rawSegs = raw;
`endif

endmodule
